// File: rtl/glitc_intercom_pkg.sv
// ---------------------------------------------------------------------------
// glitc_intercom_pkg: shared state encoding and watchdog limit for the scanner
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package glitc_intercom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // A healthy handler answers within its own latency range plus pipeline slack.
  function automatic int wd_limit(input int latency_width);
    return (1 << latency_width) + 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/glitc_intercom_echo_stats.sv
// ---------------------------------------------------------------------------
// glitc_intercom_echo_stats: seen/missed counters and latency min/max/sum
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module glitc_intercom_echo_stats
  import glitc_intercom_pkg::*;
#(
  parameter int LATENCY_WIDTH = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 hit,
  input  logic                                 miss,
  input  logic [LATENCY_WIDTH-1:0]             latency,
  output logic [COUNT_WIDTH-1:0]               seen_cnt,
  output logic [COUNT_WIDTH-1:0]               missed_cnt,
  output logic [LATENCY_WIDTH-1:0]             min_lat,
  output logic [LATENCY_WIDTH-1:0]             max_lat,
  output logic [LATENCY_WIDTH+COUNT_WIDTH-1:0] sum_lat
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_cnt   <= '0;
      missed_cnt <= '0;
      min_lat    <= '1;
      max_lat    <= '0;
      sum_lat    <= '0;
    end else if (clear) begin
      seen_cnt   <= '0;
      missed_cnt <= '0;
      min_lat    <= '1;
      max_lat    <= '0;
      sum_lat    <= '0;
    end else begin
      if (hit) begin
        seen_cnt <= seen_cnt + 1'b1;
        sum_lat  <= sum_lat + (LATENCY_WIDTH+COUNT_WIDTH)'(latency);
        if (latency < min_lat) min_lat <= latency;
        if (latency > max_lat) max_lat <= latency;
      end
      if (miss) missed_cnt <= missed_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/glitc_intercom_echo_scanner.sv
// ---------------------------------------------------------------------------
// glitc_intercom_echo_scanner: issues echo trials and gathers link statistics
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module glitc_intercom_echo_scanner
  import glitc_intercom_pkg::*;
#(
  parameter int LATENCY_WIDTH = 4,
  parameter int COUNT_WIDTH   = 8,
  parameter int GAP_WIDTH     = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 start_i,
  input  logic                                 abort_i,
  input  logic [COUNT_WIDTH-1:0]               count_i,
  input  logic [GAP_WIDTH-1:0]                 gap_i,
  output logic                                 echo_send_o,
  output logic                                 status_rst_o,
  input  logic                                 echo_ready_i,
  input  logic                                 echo_seen_i,
  input  logic [LATENCY_WIDTH-1:0]             echo_latency_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 aborted_o,
  output logic [COUNT_WIDTH-1:0]               sent_o,
  output logic [COUNT_WIDTH-1:0]               seen_o,
  output logic [COUNT_WIDTH-1:0]               missed_o,
  output logic [LATENCY_WIDTH-1:0]             min_latency_o,
  output logic [LATENCY_WIDTH-1:0]             max_latency_o,
  output logic [LATENCY_WIDTH+COUNT_WIDTH-1:0] sum_latency_o
);

  localparam int WD_LIMIT = wd_limit(LATENCY_WIDTH);
  localparam int WD_WIDTH = $clog2(WD_LIMIT + 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] sent_q;
  logic [GAP_WIDTH-1:0]   gap_q;
  logic [GAP_WIDTH-1:0]   gap_cnt;
  logic [WD_WIDTH-1:0]    wd_cnt;
  logic                   aborted_q;

  logic start_run;
  logic run_abort;
  logic result;
  logic timeout;

  assign start_run = (state == ST_IDLE) && start_i;
  // DONE already leads back to IDLE, so an abort there has nothing to stop.
  assign run_abort = abort_i && (state != ST_IDLE) && (state != ST_DONE);
  assign result    = (state == ST_WAIT) && echo_ready_i;
  assign timeout   = (state == ST_WAIT) && !echo_ready_i &&
                     (wd_cnt == WD_WIDTH'(WD_LIMIT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_i) state_nxt = (count_i == '0) ? ST_DONE : ST_CLEAR;
      ST_CLEAR: state_nxt = ST_SEND;
      ST_SEND:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (result) begin
          if (sent_q == count_q)  state_nxt = ST_DONE;
          else if (gap_q != '0)   state_nxt = ST_GAP;
          else                    state_nxt = ST_SEND;
        end else if (timeout) begin
          state_nxt = ST_DONE;
        end
      end
      ST_GAP:   if (gap_cnt == GAP_WIDTH'(1)) state_nxt = ST_SEND;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (run_abort) state_nxt = ST_DONE;
  end

  always_comb begin
    status_rst_o = (state == ST_CLEAR);
    echo_send_o  = (state == ST_SEND);
    busy_o       = (state != ST_IDLE);
    done_o       = (state == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q   <= '0;
      gap_q     <= '0;
      sent_q    <= '0;
      gap_cnt   <= '0;
      wd_cnt    <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (start_run) begin
        sent_q <= '0;
        if (count_i != '0) begin
          count_q   <= count_i;
          gap_q     <= gap_i;
          aborted_q <= 1'b0;
        end
      end
      if ((state == ST_SEND) && !abort_i) sent_q <= sent_q + 1'b1;
      if (state == ST_SEND)      wd_cnt <= '0;
      else if (state == ST_WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (result)                gap_cnt <= gap_q;
      else if (state == ST_GAP)  gap_cnt <= gap_cnt - 1'b1;
      if (run_abort || timeout) aborted_q <= 1'b1;
    end
  end

  assign sent_o    = sent_q;
  assign aborted_o = aborted_q;

  glitc_intercom_echo_stats #(
    .LATENCY_WIDTH (LATENCY_WIDTH),
    .COUNT_WIDTH   (COUNT_WIDTH)
  ) u_stats (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .clear      (start_run),
    .hit        (result && echo_seen_i),
    .miss       ((result && !echo_seen_i) || (timeout && !abort_i)),
    .latency    (echo_latency_i),
    .seen_cnt   (seen_o),
    .missed_cnt (missed_o),
    .min_lat    (min_latency_o),
    .max_lat    (max_latency_o),
    .sum_lat    (sum_latency_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_glitc_intercom_echo_scanner.sv
// ---------------------------------------------------------------------------
// tb_glitc_intercom_echo_scanner: timeline reference model plus handler model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_glitc_intercom_echo_scanner;

  localparam int WD = 20;  // 2^4 + 4 wait cycles

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        start_i = 1'b0, abort_i = 1'b0;
  logic [7:0]  count_i = '0, gap_i = '0;
  logic        echo_send_o, status_rst_o;
  logic        echo_ready_i = 1'b0, echo_seen_i = 1'b0;
  logic [3:0]  echo_latency_i = '0;
  logic        busy_o, done_o, aborted_o;
  logic [7:0]  sent_o, seen_o, missed_o;
  logic [3:0]  min_latency_o, max_latency_o;
  logic [11:0] sum_latency_o;

  glitc_intercom_echo_scanner dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
    .count_i(count_i), .gap_i(gap_i), .echo_send_o(echo_send_o),
    .status_rst_o(status_rst_o), .echo_ready_i(echo_ready_i),
    .echo_seen_i(echo_seen_i), .echo_latency_i(echo_latency_i),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .sent_o(sent_o), .seen_o(seen_o), .missed_o(missed_o),
    .min_latency_o(min_latency_o), .max_latency_o(max_latency_o),
    .sum_latency_o(sum_latency_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0, n_done = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs as a timeline of scheduled cycles.
  int cyc = 0, done_at, clr_at, send_at, wtime;
  int m_count, m_gap, m_sent, m_seen, m_missed, m_min, m_max, m_sum;
  bit m_busy, waiting, m_abt;

  task automatic clear_stats();
    m_sent = 0; m_seen = 0; m_missed = 0; m_min = 15; m_max = 0; m_sum = 0;
  endtask

  task automatic mreset();
    m_busy = 0; waiting = 0; m_abt = 0;
    done_at = -100; clr_at = -100; send_at = -100;
    clear_stats();
  endtask

  task automatic mstep();
    cyc++;
    if (!m_busy) begin
      if (start_i) begin
        clear_stats();
        m_busy = 1;
        if (count_i == 0) done_at = cyc;
        else begin
          m_count = count_i; m_gap = gap_i; m_abt = 0;
          clr_at = cyc; send_at = cyc + 1;
        end
      end
    end else if (done_at == cyc - 1) begin
      m_busy = 0;
    end else begin
      if (waiting && echo_ready_i) begin
        if (echo_seen_i) begin
          m_seen++; m_sum += echo_latency_i;
          if (echo_latency_i < m_min) m_min = echo_latency_i;
          if (echo_latency_i > m_max) m_max = echo_latency_i;
        end else m_missed++;
      end
      if (abort_i) begin
        done_at = cyc; m_abt = 1; waiting = 0; send_at = -100; clr_at = -100;
      end else if (send_at == cyc - 1) begin
        m_sent++; waiting = 1; wtime = 0;
      end else if (waiting) begin
        wtime++;
        if (echo_ready_i) begin
          waiting = 0;
          if (m_sent == m_count) done_at = cyc;
          else send_at = cyc + m_gap;
        end else if (wtime == WD) begin
          m_missed++; m_abt = 1; done_at = cyc; waiting = 0;
        end
      end
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk_i or negedge rst_n_i);
      if (!rst_n_i) mreset();
      else          mstep();
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (chk_en) begin
      check("busy",       32'(busy_o),        32'(m_busy));
      check("done",       32'(done_o),        32'(done_at == cyc));
      check("status_rst", 32'(status_rst_o),  32'(clr_at == cyc));
      check("echo_send",  32'(echo_send_o),   32'(send_at == cyc));
      check("aborted",    32'(aborted_o),     32'(m_abt));
      check("sent",       32'(sent_o),        32'(m_sent));
      check("seen",       32'(seen_o),        32'(m_seen));
      check("missed",     32'(missed_o),      32'(m_missed));
      check("min_lat",    32'(min_latency_o), 32'(m_min));
      check("max_lat",    32'(max_latency_o), 32'(m_max));
      check("sum_lat",    32'(sum_latency_o), 32'(m_sum));
      if (done_o) n_done++;
    end
  end

  // Handler model: answers each echo request after a delay.
  logic [3:0] lat_tab [16];
  bit         seen_tab [16];
  int  remaining = 0, delay_cfg = 2, trial_idx = 0, n_results = 0;
  bit  no_resp = 0, use_tab = 1, spurious = 0, rand_delay = 0;
  bit  cur_seen;
  logic [3:0] cur_lat;

  initial forever begin
    @(negedge clk_i or negedge rst_n_i);
    if (!rst_n_i) begin
      remaining = 0; echo_ready_i = 1'b0;
    end else begin
      echo_ready_i = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          echo_ready_i = 1'b1; echo_seen_i = cur_seen; echo_latency_i = cur_lat;
          n_results++;
        end
      end else if (spurious && $urandom_range(0, 7) == 0) begin
        echo_ready_i = 1'b1; echo_seen_i = 1'($urandom); echo_latency_i = 4'($urandom);
      end
      if (echo_send_o) begin
        if (use_tab) begin
          cur_lat = lat_tab[trial_idx % 16]; cur_seen = seen_tab[trial_idx % 16];
        end else begin
          cur_lat = 4'($urandom_range(0, 15)); cur_seen = ($urandom_range(0, 3) != 0);
        end
        trial_idx++;
        if (!no_resp) remaining = rand_delay ? int'($urandom_range(1, 8)) : delay_cfg;
      end
    end
  end

  task automatic fill(input int lat);
    for (int i = 0; i < 16; i++) begin lat_tab[i] = 4'(lat); seen_tab[i] = 1; end
  endtask

  task automatic start_run(input int cnt, input int gp);
    @(negedge clk_i);
    start_i = 1'b1; count_i = 8'(cnt); gap_i = 8'(gp); trial_idx = 0;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin got = 1; break; end
      @(negedge clk_i);
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic expect_stats(input string tag, input int s, input int sn, input int ms,
                              input int mn, input int mx, input int sm, input int ab);
    check({tag, "_sent"},    32'(sent_o),        32'(s));
    check({tag, "_seen"},    32'(seen_o),        32'(sn));
    check({tag, "_missed"},  32'(missed_o),      32'(ms));
    check({tag, "_min"},     32'(min_latency_o), 32'(mn));
    check({tag, "_max"},     32'(max_latency_o), 32'(mx));
    check({tag, "_sum"},     32'(sum_latency_o), 32'(sm));
    check({tag, "_aborted"}, 32'(aborted_o),     32'(ab));
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int d0;
  bit seen_send;

  initial begin
    fill(5);
    #1 rst_n_i = 1'b0;
    #1 chk_en = 1;
    expect_stats("reset", 0, 0, 0, 15, 0, 0, 0);
    check("reset_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Constant latency 5, back-to-back trials.
    d0 = n_done;
    start_run(8, 0);
    wait_done(400, "s1_done");
    expect_stats("s1", 8, 8, 0, 5, 5, 40, 0);
    repeat (5) @(negedge clk_i);
    check("s1_done_pulses", 32'(n_done - d0), 32'd1);

    // Latency spread with a 2-cycle gap.
    lat_tab[0] = 4'd3; lat_tab[1] = 4'd9; lat_tab[2] = 4'd1; lat_tab[3] = 4'd15;
    start_run(4, 2);
    wait_done(400, "s2_done");
    expect_stats("s2", 4, 4, 0, 1, 15, 28, 0);
    repeat (5) @(negedge clk_i);

    // Trials 2 and 5 return no echo.
    fill(4); seen_tab[1] = 0; seen_tab[4] = 0;
    start_run(6, 1);
    wait_done(400, "s3_done");
    expect_stats("s3", 6, 4, 2, 4, 4, 16, 0);
    repeat (5) @(negedge clk_i);

    // Silent handler trips the watchdog.
    fill(5); no_resp = 1;
    start_run(3, 0);
    wait_done(100, "s4_done");
    expect_stats("s4", 1, 0, 1, 15, 0, 0, 1);
    no_resp = 0;
    repeat (5) @(negedge clk_i);

    // Abort in the gap after trial 3, with a stray start mid-run.
    start_run(10, 3);
    repeat (4) @(negedge clk_i);
    start_i = 1'b1; count_i = 8'd1;
    @(negedge clk_i);
    start_i = 1'b0;
    d0 = n_results - 1;
    for (int i = 0; i < 300 && (n_results - d0) < 3; i++) @(negedge clk_i);
    check("s5_results_reached", 32'(n_results - d0 >= 3), 32'd1);
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("s5_done_next", 32'(done_o), 32'd1);
    expect_stats("s5", 3, 3, 0, 5, 5, 15, 1);
    repeat (3) @(negedge clk_i);
    start_run(0, 0);
    wait_done(5, "s5_zero_done");
    expect_stats("s5z", 0, 0, 0, 15, 0, 0, 1);
    repeat (5) @(negedge clk_i);

    // Reset in the middle of WAIT.
    delay_cfg = 6;
    start_run(5, 0);
    seen_send = 0;
    for (int i = 0; i < 20 && !seen_send; i++) begin
      @(negedge clk_i);
      seen_send = echo_send_o;
    end
    check("s6_send_seen", 32'(seen_send), 32'd1);
    repeat (2) @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    expect_stats("s6rst", 0, 0, 0, 15, 0, 0, 0);
    check("s6rst_busy", 32'(busy_o), 32'd0);
    check("s6rst_done", 32'(done_o), 32'd0);
    d0 = n_done;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("s6_no_done", 32'(n_done - d0), 32'd0);
    delay_cfg = 2;
    start_run(2, 1);
    wait_done(200, "s6_done");
    expect_stats("s6", 2, 2, 0, 5, 5, 10, 0);
    repeat (5) @(negedge clk_i);

    // Randomized runs with stray strobes, aborts and starts.
    use_tab = 0; rand_delay = 1; spurious = 1;
    for (int r = 0; r < 15; r++) begin
      bit got = 0;
      start_run($urandom_range(1, 12), $urandom_range(0, 4));
      for (int i = 0; i < 800; i++) begin
        if (done_o) begin got = 1; break; end
        abort_i = ($urandom_range(0, 79) == 0);
        start_i = ($urandom_range(0, 39) == 0);
        count_i = 8'($urandom_range(0, 5));
        @(negedge clk_i);
      end
      check("rand_done", 32'(got), 32'd1);
      abort_i = 1'b0; start_i = 1'b0;
      repeat (12) @(negedge clk_i);
    end
    spurious = 0;
    repeat (3) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/glitc_intercom_echo_scanner.md
# glitc_intercom_echo_scanner

Test sequencer placed directly upstream of the intercom echo handler. On a start command it issues a programmed number of echo requests to the handler, waits for each result, and accumulates link statistics: sent/seen/missed counts and min/max/sum of round-trip latency. Software or the control register block programs it and reads the results.

## Interface
- LATENCY_WIDTH, 4: width of the handler's latency value.
- COUNT_WIDTH, 8: width of the trial count and of the sent/seen/missed counters.
- GAP_WIDTH, 8: width of the inter-trial idle count.

- clk_i  in  1  system clock; one clock, all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- abort_i  in  1  one-cycle abort pulse.
- count_i  in  COUNT_WIDTH  number of trials, latched on start.
- gap_i  in  GAP_WIDTH  idle cycles between trials, latched on start.
- echo_send_o  out  1  one-cycle request to the handler.
- status_rst_o  out  1  one-cycle clear to the handler's status.
- echo_ready_i  in  1  handler result strobe.
- echo_seen_i  in  1  echo returned; valid with echo_ready_i.
- echo_latency_i  in  LATENCY_WIDTH  latency; valid with echo_ready_i.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle completion pulse.
- aborted_o  out  1  last run ended by abort or watchdog.
- sent_o, seen_o, missed_o  out  COUNT_WIDTH  trial counters.
- min_latency_o, max_latency_o  out  LATENCY_WIDTH  latency extremes over seen trials.
- sum_latency_o  out  LATENCY_WIDTH+COUNT_WIDTH  latency sum over seen trials.

## Operation
- States: IDLE, CLEAR, SEND, WAIT, GAP, DONE.
- IDLE + start_i, count_i≠0: latch count and gap, clear statistics, clear aborted_o, go to CLEAR.
- IDLE + start_i, count_i=0: clear statistics, go to DONE. Statistics stay at their cleared values.
- Cleared statistics: counters 0, min all-ones, max 0, sum 0.
- CLEAR: status_rst_o=1 for one cycle, then SEND.
- SEND: echo_send_o=1 for one cycle, sent_o+1, watchdog cleared, then WAIT.
- WAIT: on echo_ready_i, the trial ends.
  - If echo_seen_i=1: seen_o+1, sum += latency, min and max updated.
  - Otherwise: missed_o+1.
  - Next state: DONE if sent_o==count; GAP if gap≠0; else SEND.
- Watchdog: WAIT lasting 2^LATENCY_WIDTH+4 cycles without echo_ready_i counts as a miss, sets aborted_o, and goes to DONE.
- GAP: stays exactly gap cycles, then SEND.
- DONE: done_o=1 for one cycle, busy_o=0 from the next cycle, then IDLE.
- abort_i in any non-IDLE state: next state DONE, aborted_o=1. Counters freeze. A trial already in flight is not counted as missed.
- abort_i in IDLE: no effect.
- abort_i and echo_ready_i in the same WAIT cycle: the result is recorded first, then DONE.
- echo_ready_i outside WAIT: ignored.
- Arithmetic: counters cannot overflow (bounded by count); sum width is sufficient by construction.

## Timing
- Reset values: all outputs 0 except min_latency_o = all-ones. State resets to IDLE.
- Reset asserted mid-run: immediate return to IDLE. No done_o is generated.
- start_i at edge N: status_rst_o high in cycle N+1, echo_send_o high in cycle N+2, busy_o high from N+1.
- Result taken at edge E: statistics are visible at E+1.
- Next echo_send_o:
  - at E+1 when gap=0;
  - at E+1+gap otherwise.
- done_o fires in the cycle after the final result, or after the abort/watchdog cycle. Statistics are already stable when done_o is high.
- start_i in the same cycle as done_o: ignored. A new start is accepted from the following cycle.

## Structure
- Shared package glitc_intercom_pkg:
  - state enumeration;
  - watchdog limit function of LATENCY_WIDTH.
- Sub-module glitc_intercom_echo_stats: min/max/sum/seen/missed accumulator with clear and update strobes. The FSM, gap counter and watchdog stay in the top module.

## Test plan
- Bench handler model, echo_latency_i=5, seen=1. count=8, gap=0 → sent=seen=8, missed=0, min=max=5, sum=40, one done_o.
- Latencies 3,9,1,15, count=4, gap=2 → min=1, max=15, sum=28. Send pulses are 3 cycles after each result strobe.
- Model returns seen=0 on trials 2 and 5, count=6 → seen=4, missed=2, sent=6, aborted_o=0.
- Model never responds, count=3 → after 20 WAIT cycles: missed=1, sent=1, aborted_o=1, done_o.
- abort_i during GAP of trial 3 of 10 → sent=3, done_o next cycle, aborted_o=1. start_i during the run is ignored, start_i with count=0 gives done_o with zeroed stats.
- rst_n_i low mid-WAIT → all outputs at reset values at once, min=all-ones, no done_o. Following start runs normally.
